// File: rtl/axi_tpqueue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_tpqueue_pkg
// Desc     : Helpers shared by the axi_tpqueue block. This package holds only
//            the find-first-one helper. Widths stay as module parameters.
// Revision : 1.0 - initial release
// ============================================================================
package axi_tpqueue_pkg;

    // Returns the index of the lowest set bit among the low `width` bits of
    // vec. Returns `width` when none of those bits is set.
    function automatic int find_first_one(input logic [63:0] vec, input int width);
        int r_idx;
        r_idx = width;
        for (int i = 63; i >= 0; i--) begin
            if ((i < width) && vec[i]) begin
                r_idx = i;
            end
        end
        return r_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_tpqueue_ffs.sv
`default_nettype none
// ============================================================================
// Module   : axi_tpqueue_ffs
// Desc     : Oldest-hit selector. Produces a one-hot copy of the lowest set
//            bit of i_vec, scanning from index 0 upward. The output is zero
//            when no bit of i_vec is set.
// Revision : 1.0 - initial release
// ============================================================================
module axi_tpqueue_ffs
    import axi_tpqueue_pkg::*;
#(
    parameter int DP = 4
) (
    input  logic [DP-1:0] i_vec,
    output logic [DP-1:0] o_onehot
);

    int w_idx;

    // Locate the first hit and expand its index back to a one-hot vector.
    always_comb begin
        w_idx    = find_first_one(64'(i_vec), DP);
        o_onehot = '0;
        for (int i = 0; i < DP; i++) begin
            o_onehot[i] = (w_idx == i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_tpqueue.sv
`default_nettype none
// ============================================================================
// Module   : axi_tpqueue
// Desc     : Age-ordered, compacting entry queue with a key search. Supports
//            push (append), pop (retire oldest) and delete-by-index. Valid
//            entries always occupy indices 0..count-1. A per-entry key match
//            and a one-hot oldest match are produced combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module axi_tpqueue
    import axi_tpqueue_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int DP = 4,
    parameter  int KW = 4,
    localparam int AW = $clog2(DP),
    localparam int CW = $clog2(DP + 1)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic [DW-1:0]    i_data,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_del,
    input  logic [AW-1:0]    i_del_idx,
    input  logic [KW-1:0]    i_key,
    output logic [DP*DW-1:0] o_data,
    output logic [DP-1:0]    o_valid,
    output logic [DP-1:0]    o_match,
    output logic [DP-1:0]    o_first,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_err
);

    localparam logic [CW-1:0] c_DEPTH = CW'(DP);

    logic [DW-1:0] r_data [DP];
    logic [DP-1:0] r_valid;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_full;
    logic          w_empty;
    logic          w_pop_ok;
    logic          w_del_ok;
    logic          w_rm_en;
    logic [AW-1:0] w_rm_idx;
    logic          w_wr_en;
    logic [CW-1:0] w_wr_idx;
    logic [CW-1:0] w_count_nxt;
    logic          w_err;
    logic [DW-1:0] w_above    [DP];
    logic [DW-1:0] w_data_nxt [DP];
    logic [DP-1:0] w_match;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Retire decode: a pop wins over a delete; a delete needs a live index.
    assign w_pop_ok = i_pop && !w_empty;
    assign w_del_ok = i_del && !i_pop && (CW'(i_del_idx) < r_count);
    assign w_rm_en  = w_pop_ok || w_del_ok;
    assign w_rm_idx = i_pop ? '0 : i_del_idx;

    // A push into a full queue is allowed only if a slot frees on this edge.
    assign w_wr_en  = i_push && (!w_full || w_rm_en);
    assign w_wr_idx = w_rm_en ? (r_count - CW'(1)) : r_count;

    // Error flag: every illegal request, including the ignored half of pop+del.
    assign w_err = (i_pop && w_empty)
                || (i_pop && i_del)
                || (i_del && !i_pop && (CW'(i_del_idx) >= r_count))
                || (i_push && !w_wr_en);

    // Next occupancy: a simultaneous write and retire cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_en && !w_rm_en) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rm_en && !w_wr_en) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Neighbour feeding each slot during a shift; the top slot keeps its value.
    generate
        for (genvar g = 0; g < DP; g++) begin : g_above
            if (g < DP - 1) begin : g_shift
                assign w_above[g] = r_data[g+1];
            end else begin : g_top
                assign w_above[g] = r_data[g];
            end
        end
    endgenerate

    // Slot update: compact above the retired index, then drop in the new entry.
    always_comb begin
        for (int i = 0; i < DP; i++) begin
            w_data_nxt[i] = r_data[i];
            if (w_rm_en && (AW'(i) >= w_rm_idx)) begin
                w_data_nxt[i] = w_above[i];
            end
            if (w_wr_en && (CW'(i) == w_wr_idx)) begin
                w_data_nxt[i] = i_data;
            end
        end
    end

    // Entry state, valid thermometer, occupancy and error pulse registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DP; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            for (int i = 0; i < DP; i++) begin
                r_data[i]  <= w_data_nxt[i];
                r_valid[i] <= (CW'(i) < w_count_nxt);
            end
            r_count <= w_count_nxt;
            r_err   <= w_err;
        end
    end

    // Per-entry key comparison against the registered contents.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DP; i++) begin
            w_match[i] = r_valid[i] && (r_data[i][KW-1:0] == i_key);
        end
    end

    axi_tpqueue_ffs #(
        .DP (DP)
    ) u_ffs (
        .i_vec    (w_match),
        .o_onehot (o_first)
    );

    generate
        for (genvar g = 0; g < DP; g++) begin : g_out
            assign o_data[g*DW +: DW] = r_data[g];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_match = w_match;
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_tpqueue.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_tpqueue
// Desc     : Self-checking bench for axi_tpqueue (DW=8, DP=4, KW=4). A queue
//            model tracks the expected contents and is compared on every
//            falling edge; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_tpqueue;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int KW = 4;

    logic            clk;
    logic            rstn;
    logic [DW-1:0]   i_data;
    logic            i_push;
    logic            i_pop;
    logic            i_del;
    logic [1:0]      i_del_idx;
    logic [KW-1:0]   i_key;
    logic [DP*DW-1:0] o_data;
    logic [DP-1:0]   o_valid;
    logic [DP-1:0]   o_match;
    logic [DP-1:0]   o_first;
    logic [2:0]      o_count;
    logic            o_full;
    logic            o_empty;
    logic            o_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q [$];
    logic          m_err;

    axi_tpqueue #(
        .DW (DW),
        .DP (DP),
        .KW (KW)
    ) dut (
        .i_clk     (clk),
        .i_resetn  (rstn),
        .i_data    (i_data),
        .i_push    (i_push),
        .i_pop     (i_pop),
        .i_del     (i_del),
        .i_del_idx (i_del_idx),
        .i_key     (i_key),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_match   (o_match),
        .o_first   (o_first),
        .o_count   (o_count),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_err     (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int i);
        return o_data[i*DW +: DW];
    endfunction

    // Queue model: retire (pop before delete) then append at the young end.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            logic err;
            logic rm;
            int   idx;
            err = 1'b0;
            rm  = 1'b0;
            idx = 0;
            if (i_pop && i_del) err = 1'b1;
            if (i_pop) begin
                if (q.size() == 0) err = 1'b1;
                else begin rm = 1'b1; idx = 0; end
            end else if (i_del) begin
                if (int'(i_del_idx) >= q.size()) err = 1'b1;
                else begin rm = 1'b1; idx = int'(i_del_idx); end
            end
            if (rm) q.delete(idx);
            if (i_push) begin
                if (q.size() >= DP) err = 1'b1;
                else q.push_back(i_data);
            end
            m_err = err;
        end
    end

    // Compare all outputs with the model once per cycle, mid-period.
    always @(negedge clk) begin
        if (rstn) begin
            logic [DP-1:0] ev;
            logic [DP-1:0] em;
            logic [DP-1:0] ef;
            ev = '0;
            em = '0;
            ef = '0;
            for (int i = 0; i < q.size(); i++) begin
                ev[i] = 1'b1;
                if (q[i][KW-1:0] == i_key) em[i] = 1'b1;
            end
            for (int i = DP - 1; i >= 0; i--) begin
                if (em[i]) ef = DP'(1) << i;
            end
            chk("mdl_count", 32'(o_count), 32'(q.size()));
            chk("mdl_valid", 32'(o_valid), 32'(ev));
            chk("mdl_full",  32'(o_full),  32'(q.size() == DP));
            chk("mdl_empty", 32'(o_empty), 32'(q.size() == 0));
            chk("mdl_err",   32'(o_err),   32'(m_err));
            chk("mdl_match", 32'(o_match), 32'(em));
            chk("mdl_first", 32'(o_first), 32'(ef));
            for (int i = 0; i < q.size(); i++) begin
                chk("mdl_data", 32'(dat(i)), 32'(q[i]));
            end
        end
    end

    // One clocked request; inputs return to idle just after the edge.
    task automatic cyc(input logic push, input logic [7:0] d, input logic pop,
                       input logic del, input logic [1:0] idx);
        i_push    = push;
        i_data    = d;
        i_pop     = pop;
        i_del     = del;
        i_del_idx = idx;
        @(posedge clk);
        #1;
        i_push = 1'b0;
        i_pop  = 1'b0;
        i_del  = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        i_data    = '0;
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_del     = 1'b0;
        i_del_idx = '0;
        i_key     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_err",   32'(o_err),   32'd0);
        chk("rst_match", 32'(o_match), 32'h0);
        chk("rst_first", 32'(o_first), 32'h0);
        rstn = 1'b1;

        // Fill to full, then an overflow push.
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        cyc(1, 8'h44, 0, 0, 0);
        chk("fill_full",  32'(o_full),  32'd1);
        chk("fill_count", 32'(o_count), 32'd4);
        cyc(1, 8'h55, 0, 0, 0);
        chk("ovf_err",   32'(o_err),   32'd1);
        chk("ovf_count", 32'(o_count), 32'd4);
        chk("ovf_d3",    32'(dat(3)),  32'h44);
        cyc(0, 8'h00, 0, 0, 0);
        chk("ovf_err_clr", 32'(o_err), 32'd0);

        // Pop and push together while full.
        cyc(1, 8'h55, 1, 0, 0);
        chk("pp_d0",    32'(dat(0)),  32'h22);
        chk("pp_d1",    32'(dat(1)),  32'h33);
        chk("pp_d2",    32'(dat(2)),  32'h44);
        chk("pp_d3",    32'(dat(3)),  32'h55);
        chk("pp_count", 32'(o_count), 32'd4);
        chk("pp_err",   32'(o_err),   32'd0);

        // Drain, then pop while empty.
        repeat (4) cyc(0, 8'h00, 1, 0, 0);
        chk("drain_empty", 32'(o_empty), 32'd1);
        cyc(0, 8'h00, 1, 0, 0);
        chk("upop_err",   32'(o_err),   32'd1);
        chk("upop_count", 32'(o_count), 32'd0);

        // Mid-delete compaction and illegal deletes.
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 2'd1);
        chk("del_d0",    32'(dat(0)),  32'h11);
        chk("del_d1",    32'(dat(1)),  32'h33);
        chk("del_valid", 32'(o_valid), 32'b0011);
        chk("del_count", 32'(o_count), 32'd2);
        cyc(0, 8'h00, 0, 1, 2'd3);
        chk("bdel_err",   32'(o_err),   32'd1);
        chk("bdel_count", 32'(o_count), 32'd2);
        chk("bdel_d1",    32'(dat(1)),  32'h33);
        cyc(0, 8'h00, 1, 1, 2'd1);
        chk("popdel_err",   32'(o_err),   32'd1);
        chk("popdel_count", 32'(o_count), 32'd1);
        chk("popdel_d0",    32'(dat(0)),  32'h33);
        cyc(0, 8'h00, 1, 0, 0);

        // Key search.
        cyc(1, 8'h13, 0, 0, 0);
        cyc(1, 8'h23, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        i_key = 4'h3;
        #1;
        chk("key_match", 32'(o_match), 32'b0111);
        chk("key_first", 32'(o_first), 32'b0001);
        i_key = 4'h2;
        #1;
        chk("nokey_match", 32'(o_match), 32'b0000);
        chk("nokey_first", 32'(o_first), 32'b0000);
        i_key = 4'h3;
        cyc(0, 8'h00, 1, 0, 0);
        chk("kpop_first", 32'(o_first), 32'b0001);
        chk("kpop_match", 32'(o_match), 32'b0011);
        chk("kpop_d0",    32'(dat(0)),  32'h23);
        cyc(1, 8'h45, 0, 0, 0);
        i_key = 4'h5;
        #1;
        chk("k5_match", 32'(o_match), 32'b0100);
        chk("k5_first", 32'(o_first), 32'b0100);

        // Reset asserted in the middle of a push with three entries.
        i_push = 1'b1;
        i_data = 8'h99;
        #2;
        rstn = 1'b0;
        #1;
        chk("mrst_count", 32'(o_count), 32'd0);
        chk("mrst_valid", 32'(o_valid), 32'h0);
        chk("mrst_empty", 32'(o_empty), 32'd1);
        chk("mrst_full",  32'(o_full),  32'd0);
        chk("mrst_match", 32'(o_match), 32'h0);
        chk("mrst_first", 32'(o_first), 32'h0);
        @(posedge clk);
        #1;
        i_push = 1'b0;
        rstn   = 1'b1;
        cyc(1, 8'h77, 0, 0, 0);
        chk("post_d0",    32'(dat(0)),  32'h77);
        chk("post_count", 32'(o_count), 32'd1);
        chk("post_valid", 32'(o_valid), 32'b0001);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
